seq_multiplier_msu: RTL and testbench

- Iterative, parametrised signed/unsigned/mixed multiplier with valid/ready handshakes on both sides.
- Computes the full 2*WIDTH-bit product, retiring BITS_PER_CYCLE multiplier bits per clock.
- Successor to the combinational carry-save array: trades area for latency.
- Target is the ALU/MUL unit, where a full array is too large; supports MUL/MULH/MULHSU/MULHU-style operand interpretation.

---
 rtl/mult_pkg.sv | 28 ++
 rtl/mult_step.sv | 37 +++
 rtl/seq_multiplier_msu.sv | 123 ++++++++++++
 tb/tb_seq_multiplier_msu.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential multiplier.
// Latency: n/a (types only).
// Backpressure: n/a.
package mult_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef enum logic [1:0] {MODE_UU, MODE_SS, MODE_SU} mode_t;

    // sign dominates mix: both-signed wins over signed-by-unsigned
    function automatic mode_t decode_mode(input logic sign, input logic mix);
        if (sign)
            return MODE_SS;
        else if (mix)
            return MODE_SU;
        else
            return MODE_UU;
    endfunction

    function automatic int iter_of(input int width, input int bits_per_cycle);
        return width / bits_per_cycle;
    endfunction

    function automatic int cnt_width(input int iter);
        return (iter > 1) ? $clog2(iter) : 1;
    endfunction

endpackage

// File: rtl/mult_step.sv
// One shift-add iteration: accumulate multiplicand * digit at the top, then arithmetic shift right.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module mult_step #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int ACC_W          = 2*WIDTH + BITS_PER_CYCLE + 2
) (
    input  logic signed [ACC_W-1:0]          acc,
    input  logic        [WIDTH:0]            mcand,
    input  logic        [BITS_PER_CYCLE-1:0] bits,
    input  logic                             neg_msb,
    output logic signed [ACC_W-1:0]          acc_next
);

    localparam int PP_W = WIDTH + BITS_PER_CYCLE + 2;

    logic signed [BITS_PER_CYCLE:0] digit;
    logic signed [PP_W-1:0]         mc_ext;
    logic signed [PP_W-1:0]         dg_ext;
    logic signed [PP_W-1:0]         pp;
    logic signed [ACC_W-1:0]        pp_ext;
    logic signed [ACC_W-1:0]        sum;

    always_comb begin
        // On the last step of a signed multiplier its top bit weighs negative,
        // so the digit is read as two's complement and the partial product is subtracted.
        digit    = {neg_msb & bits[BITS_PER_CYCLE-1], bits};
        mc_ext   = {{(PP_W-WIDTH-1){mcand[WIDTH]}}, mcand};
        dg_ext   = {{(PP_W-BITS_PER_CYCLE-1){digit[BITS_PER_CYCLE]}}, digit};
        pp       = mc_ext * dg_ext;
        pp_ext   = {{(ACC_W-PP_W){pp[PP_W-1]}}, pp};
        sum      = acc + (pp_ext <<< WIDTH);
        acc_next = sum >>> BITS_PER_CYCLE;
    end

endmodule

// File: rtl/seq_multiplier_msu.sv
// Iterative signed/unsigned/mixed multiplier producing the full 2*WIDTH product.
// Latency: ITER busy cycles; out_valid in cycle ITER+1 counting the accept cycle as 0.
// Backpressure: y/out_valid held in DONE until out_ready; in_ready only in IDLE.
module seq_multiplier_msu
    import mult_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 sign,
    input  logic                 mix,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   y,
    output logic                 busy
);

    localparam int ITER  = iter_of(WIDTH, BITS_PER_CYCLE);
    localparam int CNT_W = cnt_width(ITER);
    localparam int ACC_W = 2*WIDTH + BITS_PER_CYCLE + 2;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

    typedef struct packed {
        logic [WIDTH:0]   mcand;
        logic [WIDTH-1:0] mplier;
        logic             b_signed;
    } op_t;

    state_t                  state;
    op_t                     op;
    mode_t                   in_mode;
    logic                    a_signed;
    logic                    last_step;
    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;

    assign in_mode   = decode_mode(sign, mix);
    assign a_signed  = (in_mode != MODE_UU);
    assign last_step = (cnt == LAST);

    mult_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE),
        .ACC_W          (ACC_W)
    ) u_step (
        .acc      (acc),
        .mcand    (op.mcand),
        .bits     (op.mplier[BITS_PER_CYCLE-1:0]),
        .neg_msb  (last_step & op.b_signed),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            y         <= '0;
            cnt       <= '0;
            acc       <= '0;
            op        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // flush wins over a simultaneous accept
                    if (!flush && in_valid && in_ready) begin
                        op.mcand    <= {a[WIDTH-1] & a_signed, a};
                        op.mplier   <= b;
                        op.b_signed <= (in_mode == MODE_SS);
                        acc         <= '0;
                        cnt         <= '0;
                        state       <= BUSY;
                        in_ready    <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                BUSY: begin
                    if (flush) begin
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        acc       <= acc_next;
                        op.mplier <= op.mplier >> BITS_PER_CYCLE;
                        cnt       <= cnt + 1'b1;
                        if (last_step) begin
                            cnt       <= '0;
                            y         <= acc_next[2*WIDTH-1:0];
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (flush || out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier_msu.sv
// Bench for seq_multiplier_msu: directed cases and backpressure/flush/reset on a radix-2 instance,
// plus random all-mode traffic on a radix-16 instance, checked through expected-result queues.
module tb_seq_multiplier_msu;

    localparam int LIMIT = 100;

    logic clk;
    logic rst_n;

    logic        d1_in_valid, d1_in_ready, d1_sign, d1_mix, d1_flush;
    logic        d1_out_valid, d1_out_ready, d1_busy;
    logic [31:0] d1_a, d1_b;
    logic [63:0] d1_y;

    logic        d4_in_valid, d4_in_ready, d4_sign, d4_mix, d4_flush;
    logic        d4_out_valid, d4_out_ready, d4_busy;
    logic [31:0] d4_a, d4_b;
    logic [63:0] d4_y;

    int checks;
    int errors;
    logic [63:0] q1[$];
    logic [63:0] q4[$];

    seq_multiplier_msu #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .a(d1_a), .b(d1_b), .sign(d1_sign), .mix(d1_mix), .flush(d1_flush),
        .out_valid(d1_out_valid), .out_ready(d1_out_ready), .y(d1_y), .busy(d1_busy)
    );

    seq_multiplier_msu #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(d4_in_valid), .in_ready(d4_in_ready),
        .a(d4_a), .b(d4_b), .sign(d4_sign), .mix(d4_mix), .flush(d4_flush),
        .out_valid(d4_out_valid), .out_ready(d4_out_ready), .y(d4_y), .busy(d4_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic s, input logic m);
        logic signed [65:0] ea, eb, p;
        ea = (s | m) ? {{34{a[31]}}, a} : {34'b0, a};
        eb = s ? {{34{b[31]}}, b} : {34'b0, b};
        p  = ea * eb;
        return p[63:0];
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Drive one accepted operation; mode/operands are scrambled right after the accept edge.
    task automatic issue1(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic m, input logic [63:0] exp);
        @(negedge clk);
        d1_a = a; d1_b = b; d1_sign = s; d1_mix = m; d1_in_valid = 1'b1;
        q1.push_back(exp);
        @(posedge clk); #1;
        d1_in_valid = 1'b0; d1_sign = ~s; d1_mix = ~m; d1_a = $urandom; d1_b = $urandom;
    endtask

    task automatic issue4(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic m, input logic [63:0] exp);
        @(negedge clk);
        d4_a = a; d4_b = b; d4_sign = s; d4_mix = m; d4_in_valid = 1'b1;
        q4.push_back(exp);
        @(posedge clk); #1;
        d4_in_valid = 1'b0; d4_sign = ~s; d4_mix = ~m; d4_a = $urandom; d4_b = $urandom;
    endtask

    // Edges after the accept edge until out_valid; cycles since the accept cycle = n+1.
    task automatic wait_out1(output int n);
        n = 0;
        while (!d1_out_valid && n < LIMIT) begin @(posedge clk); #1; n++; end
    endtask

    task automatic wait_out4(output int n);
        n = 0;
        while (!d4_out_valid && n < LIMIT) begin @(posedge clk); #1; n++; end
    endtask

    task automatic retire1();
        @(negedge clk); d1_out_ready = 1'b1;
        @(posedge clk); #1; d1_out_ready = 1'b0;
    endtask

    task automatic retire4();
        @(negedge clk); d4_out_ready = 1'b1;
        @(posedge clk); #1; d4_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        d1_in_valid = 0; d1_a = 0; d1_b = 0; d1_sign = 0; d1_mix = 0; d1_flush = 0; d1_out_ready = 0;
        d4_in_valid = 0; d4_a = 0; d4_b = 0; d4_sign = 0; d4_mix = 0; d4_flush = 0; d4_out_ready = 0;
        #23;
        checks++;
        if ({d1_in_ready, d1_out_valid, d1_busy, d1_y} !== {1'b1, 1'b0, 1'b0, 64'h0}) begin
            errors++;
            $display("FAIL reset_d1: rdy/vld/busy/y=%b%b%b/%h expected 100/0", d1_in_ready, d1_out_valid, d1_busy, d1_y);
        end
        checks++;
        if ({d4_in_ready, d4_out_valid, d4_busy, d4_y} !== {1'b1, 1'b0, 1'b0, 64'h0}) begin
            errors++;
            $display("FAIL reset_d4: rdy/vld/busy/y=%b%b%b/%h expected 100/0", d4_in_ready, d4_out_valid, d4_busy, d4_y);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        int n;
        logic [63:0] exp;
        issue1(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001);
        wait_out1(n);
        exp = q1.pop_front();
        checks++;
        if (n + 1 !== 33) begin
            errors++;
            $display("FAIL uu_latency: out_valid in cycle %0d after accept, expected 33", n + 1);
        end
        checks++;
        if (d1_y !== exp) begin
            errors++;
            $display("FAIL uu_product: y=%h expected %h", d1_y, exp);
        end
        retire1();
        checks++;
        if ({d1_out_valid, d1_in_ready, d1_busy} !== 3'b010) begin
            errors++;
            $display("FAIL uu_retire: vld/rdy/busy=%b%b%b expected 010", d1_out_valid, d1_in_ready, d1_busy);
        end
    endtask

    task automatic test_signed_mixed();
        int n;
        logic [63:0] exp;
        logic [31:0] av[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0003};
        logic [31:0] bv[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic        sv[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic        mv[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [63:0] ev[4] = '{64'h4000_0000_0000_0000, 64'h0000_0000_0000_0001,
                               64'hFFFF_FFFF_0000_0001, 64'h0000_0001_8000_0000};
        for (int i = 0; i < 4; i++) begin
            issue1(av[i], bv[i], sv[i], mv[i], ev[i]);
            wait_out1(n);
            exp = q1.pop_front();
            checks++;
            if (!d1_out_valid || d1_y !== exp) begin
                errors++;
                $display("FAIL mode_case%0d: vld=%b y=%h expected 1/%h", i, d1_out_valid, d1_y, exp);
            end
            retire1();
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [63:0] exp;
        issue1(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1, ref_mul(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1));
        wait_out1(n);
        exp = q1.pop_front();
        @(negedge clk);
        d1_in_valid = 1'b1; d1_a = 32'h5; d1_b = 32'h5;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({d1_out_valid, d1_in_ready, d1_busy} !== 3'b101 || d1_y !== exp) begin
                errors++;
                $display("FAIL bp_hold%0d: vld/rdy/busy=%b%b%b y=%h expected 101/%h",
                         i, d1_out_valid, d1_in_ready, d1_busy, d1_y, exp);
            end
        end
        @(negedge clk); d1_in_valid = 1'b0;
        retire1();
        checks++;
        if ({d1_out_valid, d1_in_ready} !== 2'b01 || d1_y !== exp) begin
            errors++;
            $display("FAIL bp_release: vld/rdy=%b%b y=%h expected 01/%h", d1_out_valid, d1_in_ready, d1_y, exp);
        end
    endtask

    task automatic test_flush();
        logic [63:0] held;
        int seen;
        held = d1_y;
        issue1(32'hDEAD_BEEF, 32'h0000_0011, 1'b0, 1'b0, 64'h0);
        repeat (4) @(posedge clk);
        @(negedge clk); d1_flush = 1'b1;
        @(posedge clk); #1; d1_flush = 1'b0;
        q1.delete();
        checks++;
        if ({d1_busy, d1_in_ready, d1_out_valid} !== 3'b010) begin
            errors++;
            $display("FAIL flush_busy: busy/rdy/vld=%b%b%b expected 010", d1_busy, d1_in_ready, d1_out_valid);
        end
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (d1_out_valid) seen++; end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL flush_no_output: out_valid seen %0d cycles, expected 0", seen);
        end
        // flush together with in_valid in IDLE must not start an operation
        @(negedge clk); d1_flush = 1'b1; d1_in_valid = 1'b1; d1_a = 32'h3; d1_b = 32'h3;
        @(posedge clk); #1; d1_flush = 1'b0; d1_in_valid = 1'b0;
        checks++;
        if ({d1_busy, d1_in_ready} !== 2'b01 || d1_y !== held) begin
            errors++;
            $display("FAIL flush_idle_priority: busy/rdy=%b%b y=%h expected 01/%h", d1_busy, d1_in_ready, d1_y, held);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [63:0] exp;
        issue1(32'hCAFE_F00D, 32'h1357_9BDF, 1'b1, 1'b0, 64'h0);
        repeat (19) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        q1.delete();
        checks++;
        if ({d1_in_ready, d1_out_valid, d1_busy, d1_y} !== {1'b1, 1'b0, 1'b0, 64'h0}) begin
            errors++;
            $display("FAIL reset_mid: rdy/vld/busy=%b%b%b y=%h expected 100/0", d1_in_ready, d1_out_valid, d1_busy, d1_y);
        end
        @(negedge clk); rst_n = 1'b1;
        issue1(32'd7, 32'd6, 1'b0, 1'b0, 64'd42);
        wait_out1(n);
        exp = q1.pop_front();
        checks++;
        if (!d1_out_valid || d1_y !== exp) begin
            errors++;
            $display("FAIL after_reset_7x6: vld=%b y=%h expected 1/%h", d1_out_valid, d1_y, exp);
        end
        retire1();
    endtask

    task automatic test_random_bpc1();
        int n;
        logic [31:0] a, b;
        logic s, m;
        logic [63:0] exp;
        for (int i = 0; i < 40; i++) begin
            a = pick_operand(); b = pick_operand();
            s = 1'($urandom_range(0, 1)); m = 1'($urandom_range(0, 1));
            issue1(a, b, s, m, ref_mul(a, b, s, m));
            wait_out1(n);
            exp = q1.pop_front();
            checks++;
            if (!d1_out_valid || n + 1 !== 33 || d1_y !== exp) begin
                errors++;
                $display("FAIL rand1_%0d: a=%h b=%h s=%b m=%b vld=%b lat=%0d y=%h expected lat 33 y %h",
                         i, a, b, s, m, d1_out_valid, n + 1, d1_y, exp);
            end
            retire1();
        end
    endtask

    task automatic test_bpc4_random();
        int n;
        logic [31:0] a, b;
        logic s, m;
        logic [63:0] exp;
        for (int i = 0; i < 1000; i++) begin
            a = pick_operand(); b = pick_operand();
            s = 1'($urandom_range(0, 1)); m = 1'($urandom_range(0, 1));
            issue4(a, b, s, m, ref_mul(a, b, s, m));
            wait_out4(n);
            exp = q4.pop_front();
            checks++;
            if (n + 1 !== 9) begin
                errors++;
                $display("FAIL bpc4_latency_%0d: out_valid in cycle %0d after accept, expected 9", i, n + 1);
            end
            checks++;
            if (d4_y !== exp) begin
                errors++;
                $display("FAIL bpc4_product_%0d: a=%h b=%h s=%b m=%b y=%h expected %h", i, a, b, s, m, d4_y, exp);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            retire4();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_unsigned();
        test_signed_mixed();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random_bpc1();
        test_bpc4_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
